// File: rtl/bram_wb_ctrl_pkg.sv
// BRAM geometry defines plus the state encoding and latency bounds
// shared by the Wishbone-to-BRAM controller.
`ifndef BRAM_WB_DEFINES
`define BRAM_WB_DEFINES
`define BRAM_ADDR_LENGTH 13
`define BRAM_BASE_ADDR   32'h3800_0000
`endif

package bram_wb_ctrl_pkg;
    localparam int LAT_MIN = 4;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_WAIT = 3'd4,
        S_ACK  = 3'd5
    } state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } req_t;
endpackage

// File: rtl/wb_byte_merge.sv
// Per-byte select between a new and an old 32-bit word; bytes with a clear
// select bit pass the old value through untouched.
module wb_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  sel,
    output logic [31:0] merged
);
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
endmodule

// File: rtl/bram_wb_ctrl.sv
// Wishbone classic slave in front of the BRAM macro: fixed-latency acks,
// byte-select writes done as read-modify-write.
module bram_wb_ctrl
    import bram_wb_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = `BRAM_BASE_ADDR,
    parameter int          ADDR_W    = `BRAM_ADDR_LENGTH,
    parameter int          LATENCY   = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_a,
    output logic [31:0]       bram_di,
    input  logic [31:0]       bram_do
);
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $fatal(1, "bram_wb_ctrl: LATENCY out of range 4..15");
    end
    if (BASE_ADDR[ADDR_W+1:0] != '0) begin : g_bad_base
        $fatal(1, "bram_wb_ctrl: BASE_ADDR not aligned to the BRAM window");
    end

    state_e            state, state_nx;
    req_t              req;
    logic [ADDR_W-1:0] adr_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rdata;
    logic [31:0]       merged;
    logic              live, in_win, accept, busy, last;
    logic              unused_lsb;

    assign unused_lsb = ^wbs_adr_i[1:0];
    assign live       = wbs_cyc_i & wbs_stb_i;
    assign in_win     = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign accept     = (state == S_IDLE) & live & in_win;
    assign busy       = (state == S_RD) | (state == S_CAP) | (state == S_WR) | (state == S_WAIT);
    // cnt holds LATENCY-k in cycle T0+k, so cnt==1 marks the cycle before ack.
    assign last       = (cnt == CNT_W'(1));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!wbs_we_i)               state_nx = S_RD;
                    else if (wbs_sel_i == 4'hF)  state_nx = S_WR;
                    else if (wbs_sel_i == 4'h0)  state_nx = S_WAIT;
                    else                         state_nx = S_RD;
                end
            end
            S_RD:   state_nx = S_CAP;
            S_CAP:  state_nx = req.we ? S_WR : (last ? S_ACK : S_WAIT);
            S_WR:   state_nx = last ? S_ACK : S_WAIT;
            S_WAIT: state_nx = last ? S_ACK : S_WAIT;
            S_ACK:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Master withdrawal abandons the cycle; a write not yet issued is lost.
        if (busy && !live) state_nx = S_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            req   <= '0;
            adr_q <= '0;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req   <= '{we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i};
                adr_q <= wbs_adr_i[ADDR_W+1:2];
                cnt   <= CNT_W'(LATENCY - 1);
            end else if (busy) begin
                cnt <= cnt - 1'b1;
            end
            if (state == S_CAP) rdata <= bram_do;
        end
    end

    // Full writes pass sel=F, so the merge yields dat without needing rdata.
    wb_byte_merge u_merge (
        .old_word (rdata),
        .new_word (req.dat),
        .sel      (req.sel),
        .merged   (merged)
    );

    assign bram_en   = (state == S_RD) | (state == S_WR);
    assign bram_we   = (state == S_WR);
    assign bram_a    = adr_q;
    assign bram_di   = (state == S_WR) ? merged : 32'h0;
    assign wbs_ack_o = (state == S_ACK);
    assign wbs_dat_o = ((state == S_ACK) && !req.we) ? rdata : 32'h0;
endmodule

// File: tb/tb_bram_wb_ctrl.sv
// Randomized bench for bram_wb_ctrl against a word-level memory model and
// a fixed-latency ack expectation.
module tb_bram_wb_ctrl;
    localparam int          AW   = 13;
    localparam int          LAT  = 10;
    localparam logic [31:0] BASE = 32'h3800_0000;
    localparam int          MAXW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   adr = 32'h0, dat = 32'h0;
    logic          ack, en, bwe;
    logic [31:0]   dat_o, bdi;
    logic [31:0]   bdo;
    logic [AW-1:0] ba;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    bram_wb_ctrl #(.BASE_ADDR(BASE), .ADDR_W(AW), .LATENCY(LAT)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .bram_en  (en),
        .bram_we  (bwe),
        .bram_a   (ba),
        .bram_di  (bdi),
        .bram_do  (bdo)
    );

    // Synchronous BRAM macro: read data appears one cycle after enable.
    always @(posedge clk) begin
        if (en) begin
            if (bwe) mem[ba] <= bdi;
            bdo <= mem[ba];
        end
    end

    function automatic logic [31:0] waddr(input int w);
        return BASE + 32'(w * 4);
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    function automatic void ref_wr(input int w, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] cur;
        logic [31:0] m;
        cur = ref_rd(w);
        for (int b = 0; b < 4; b++) begin
            m = 32'hFF << (8 * b);
            if (s[b]) cur = (cur & ~m) | (d & m);
        end
        ref_mem[w] = cur;
    endfunction

    // One bus request observed for MAXW cycles; reports what the bus and BRAM pins did.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, input int abort_at, input int reset_at,
                        output int lat, output int ack_n, output logic [31:0] rd,
                        output int wr_n, output int en_n, output logic [AW-1:0] wr_a,
                        output logic leak);
        lat = 0; ack_n = 0; rd = 32'h0; wr_n = 0; en_n = 0; wr_a = '0; leak = 1'b0;
        @(negedge clk);
        adr = a; we = w; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= MAXW; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_at) begin cyc = 1'b0; stb = 1'b0; end
            if (k == reset_at) rst = 1'b1;
            if (reset_at > 0 && k == reset_at + 1) begin rst = 1'b0; cyc = 1'b0; stb = 1'b0; end
            @(negedge clk);
            if (en) en_n++;
            if (en && bwe) begin wr_n++; wr_a = ba; end
            if (ack) begin
                ack_n++;
                if (lat == 0) begin lat = k; rd = dat_o; end
                cyc = 1'b0; stb = 1'b0;
            end else if (dat_o !== 32'h0) begin
                leak = 1'b1;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            vec_cnt++;
            if (ack !== 1'b0 || dat_o !== 32'h0 || en !== 1'b0 || bwe !== 1'b0 ||
                ba !== '0 || bdi !== 32'h0) begin
                err_cnt++;
                $display("FAIL reset_outputs: ack=%b dat_o=%h en=%b we=%b a=%h di=%h, required all zero",
                         ack, dat_o, en, bwe, ba, bdi);
            end
        end
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    endtask

    task automatic test_full_write();
        int lat, ack_n, wr_n, en_n; logic [31:0] rd; logic [AW-1:0] wa; logic leak;
        xfer(32'h3800_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        ref_wr(4, 4'hF, 32'hDEAD_BEEF);
        vec_cnt++;
        if (lat != LAT || ack_n != 1) begin
            err_cnt++; $display("FAIL full_wr_ack: latency=%0d acks=%0d, required %0d/1", lat, ack_n, LAT);
        end
        vec_cnt++;
        if (wr_n != 1 || wa !== 13'd4) begin
            err_cnt++; $display("FAIL full_wr_addr: writes=%0d addr=%0d, required 1/4", wr_n, wa);
        end
        xfer(32'h3800_0010, 1'b0, 4'h1, 32'h0, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (lat != LAT || rd !== ref_rd(4)) begin
            err_cnt++; $display("FAIL full_rd: latency=%0d data=%h, required %0d/%h", lat, rd, LAT, ref_rd(4));
        end
        vec_cnt++;
        if (leak || wr_n != 0 || en_n != 1) begin
            err_cnt++; $display("FAIL full_rd_pins: leak=%b writes=%0d enables=%0d, required 0/0/1", leak, wr_n, en_n);
        end
    endtask

    task automatic test_partial_write();
        int lat, ack_n, wr_n, en_n; logic [31:0] rd; logic [AW-1:0] wa; logic leak;
        xfer(waddr(7), 1'b1, 4'hF, 32'h1122_3344, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        ref_wr(7, 4'hF, 32'h1122_3344);
        xfer(waddr(7), 1'b1, 4'b0101, 32'hAABB_CCDD, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        ref_wr(7, 4'b0101, 32'hAABB_CCDD);
        vec_cnt++;
        if (lat != LAT || wr_n != 1 || en_n != 2) begin
            err_cnt++; $display("FAIL partial_wr: latency=%0d writes=%0d enables=%0d, required %0d/1/2", lat, wr_n, en_n, LAT);
        end
        xfer(waddr(7), 1'b0, 4'h0, 32'h0, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (rd !== ref_rd(7)) begin
            err_cnt++; $display("FAIL partial_rd: data=%h, required %h", rd, ref_rd(7));
        end
    endtask

    task automatic test_null_write();
        int lat, ack_n, wr_n, en_n; logic [31:0] rd; logic [AW-1:0] wa; logic leak;
        xfer(waddr(7), 1'b1, 4'h0, 32'hFFFF_FFFF, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (lat != LAT || ack_n != 1 || en_n != 0) begin
            err_cnt++; $display("FAIL null_wr: latency=%0d acks=%0d enables=%0d, required %0d/1/0", lat, ack_n, en_n, LAT);
        end
        xfer(waddr(7), 1'b0, 4'hF, 32'h0, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (rd !== ref_rd(7)) begin
            err_cnt++; $display("FAIL null_rd: data=%h, required %h", rd, ref_rd(7));
        end
    endtask

    task automatic test_out_of_window();
        int lat, ack_n, wr_n, en_n; logic [31:0] rd; logic [AW-1:0] wa; logic leak;
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (ack_n != 0 || en_n != 0) begin
            err_cnt++; $display("FAIL oow_low: acks=%0d enables=%0d, required 0/0", ack_n, en_n);
        end
        xfer(BASE + 32'(4 << AW), 1'b1, 4'hF, 32'h1234_5678, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (ack_n != 0 || en_n != 0) begin
            err_cnt++; $display("FAIL oow_high: acks=%0d enables=%0d, required 0/0", ack_n, en_n);
        end
    endtask

    task automatic test_abort();
        int lat, ack_n, wr_n, en_n; logic [31:0] rd; logic [AW-1:0] wa; logic leak;
        logic [31:0] v;
        v = $urandom;
        xfer(waddr(9), 1'b1, 4'hF, v, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        ref_wr(9, 4'hF, v);
        xfer(waddr(9), 1'b1, 4'b0110, ~v, 1, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (ack_n != 0 || wr_n != 0) begin
            err_cnt++; $display("FAIL abort_wr: acks=%0d writes=%0d, required 0/0", ack_n, wr_n);
        end
        xfer(waddr(9), 1'b0, 4'hF, 32'h0, 0, 5, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (ack_n != 0) begin
            err_cnt++; $display("FAIL reset_abort: acks=%0d, required 0", ack_n);
        end
        xfer(waddr(9), 1'b0, 4'hF, 32'h0, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
        vec_cnt++;
        if (lat != LAT || rd !== ref_rd(9)) begin
            err_cnt++; $display("FAIL abort_rd: latency=%0d data=%h, required %0d/%h", lat, rd, LAT, ref_rd(9));
        end
    endtask

    task automatic test_back_to_back();
        int first, second; logic [31:0] d1, d2;
        first = 0; second = 0; d1 = 32'h0; d2 = 32'h0;
        @(negedge clk);
        adr = waddr(4); we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 3 * LAT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) begin
                if (first == 0) begin first = k; d1 = dat_o; adr = waddr(7); end
                else if (second == 0) begin second = k; d2 = dat_o; cyc = 1'b0; stb = 1'b0; end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        vec_cnt++;
        if (first != LAT || second - first != LAT + 1) begin
            err_cnt++; $display("FAIL b2b_timing: first=%0d gap=%0d, required %0d/%0d", first, second - first, LAT, LAT + 1);
        end
        vec_cnt++;
        if (d1 !== ref_rd(4) || d2 !== ref_rd(7)) begin
            err_cnt++; $display("FAIL b2b_data: %h %h, required %h %h", d1, d2, ref_rd(4), ref_rd(7));
        end
    endtask

    task automatic test_random();
        int lat, ack_n, wr_n, en_n; logic [31:0] rd; logic [AW-1:0] wa; logic leak;
        int w, op; logic [3:0] s; logic [31:0] d; logic oow;
        for (int i = 0; i < 40; i++) begin
            w   = $urandom_range(0, 15);
            op  = $urandom_range(0, 3);
            s   = 4'($urandom);
            d   = $urandom;
            oow = ($urandom_range(0, 7) == 0);
            if (op == 1) s = 4'hF;
            xfer(oow ? (waddr(w) ^ 32'h0100_0000) : (waddr(w) | 32'($urandom_range(0, 3))),
                 op != 0, s, d, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
            vec_cnt++;
            if (oow) begin
                if (ack_n != 0 || en_n != 0) begin
                    err_cnt++; $display("FAIL rnd_oow[%0d]: acks=%0d enables=%0d, required 0/0", i, ack_n, en_n);
                end
            end else if (op == 0) begin
                if (lat != LAT || ack_n != 1 || rd !== ref_rd(w) || leak) begin
                    err_cnt++; $display("FAIL rnd_rd[%0d]: word=%0d latency=%0d data=%h leak=%b, required %0d/%h/0",
                                        i, w, lat, rd, leak, LAT, ref_rd(w));
                end
            end else begin
                ref_wr(w, s, d);
                if (lat != LAT || ack_n != 1 || wr_n != ((s != 4'h0) ? 1 : 0) || rd !== 32'h0) begin
                    err_cnt++; $display("FAIL rnd_wr[%0d]: word=%0d sel=%h latency=%0d writes=%0d dat_o=%h, required %0d/%0d/0",
                                        i, w, s, lat, wr_n, rd, LAT, (s != 4'h0) ? 1 : 0);
                end
            end
        end
        for (int w2 = 0; w2 < 16; w2++) begin
            xfer(waddr(w2), 1'b0, 4'hF, 32'h0, 0, 0, lat, ack_n, rd, wr_n, en_n, wa, leak);
            vec_cnt++;
            if (rd !== ref_rd(w2)) begin
                err_cnt++; $display("FAIL rnd_sweep[%0d]: data=%h, required %h", w2, rd, ref_rd(w2));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        bdo = 32'h0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_null_write();
        test_out_of_window();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
